unified_memory_arbiter: RTL and testbench
=========================================

Name: unified_memory_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch path and the load/store path of the core, so the processor can move off separate instruction and data memories.
- Runs a three-state access sequencer with round-robin arbitration and a fixed memory latency counter.
- Each accepted request gets exactly one one-cycle ready pulse with the read data.
- Sits between program_counter/instruction fetch, the load/store datapath and the memory macro.

Parameters:
ADDR_WIDTH, 64, width of all address buses
DATA_WIDTH, 64, width of all data buses
MEM_LATENCY, 2, cycles the memory enable is held per access; legal range 1..15

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state and outputs
ifetch_req  input  1  fetch request; held until ifetch_ready
ifetch_address  input  ADDR_WIDTH  fetch address
ifetch_ready  output  1  one-cycle completion pulse for fetch
ifetch_rdata  output  DATA_WIDTH  fetch data; valid while ifetch_ready=1
data_req  input  1  load/store request; held until data_ready
data_we  input  1  1=store, 0=load
data_address  input  ADDR_WIDTH  load/store address
data_wdata  input  DATA_WIDTH  store data
data_ready  output  1  one-cycle completion pulse for load/store
data_rdata  output  DATA_WIDTH  load data; valid while data_ready=1; 0 for stores
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_address  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data; sampled on the last access cycle
arb_busy  output  1  1 in ACCESS and RESPOND states
grant_owner  output  1  0=fetch, 1=data; owner of the current or last access

Behaviour:
- Reset: state=IDLE; every output=0; last_grant=fetch, so data wins the first tie; latency counter=0.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that requester.
- IDLE, both requests: grant the requester opposite to last_grant (round-robin).
- On grant:
  - Latch address, wdata and we. Fetch forces we=0.
  - Set grant_owner and last_grant.
  - Load counter with MEM_LATENCY-1 and move to ACCESS.
- ACCESS:
  - mem_en=1, and mem_address/mem_wdata/mem_we are driven from the latched values. Outputs are registered, so there is no combinational path from req to mem.
  - The counter decrements each cycle.
  - When counter==0: capture mem_rdata (or 0 for stores) into the response register and move to RESPOND.
- RESPOND:
  - Exactly one of ifetch_ready/data_ready is 1 for one cycle, with rdata valid.
  - mem_en=0. Next state is IDLE.
- Latency: a request first seen in IDLE at cycle N gives ready at cycle N+MEM_LATENCY+1. Max throughput is one access per MEM_LATENCY+2 cycles.
- Request still high in the IDLE cycle after ready: treated as a new request.
- Requester drops req mid-access: the access still completes and ready still pulses. A store is never aborted.
- Input changes during ACCESS are ignored because the request is already latched.
- rdata outputs hold their value after ready falls. The value is meaningful only while ready=1.
- Reset asserted mid-access:
  - Next edge returns to IDLE with all outputs 0 and no ready pulse.
  - The aborted store may or may not have reached memory.
- Starvation bound: with both requesters continuously asserting, each is served at least every 2*(MEM_LATENCY+2) cycles.

Optional Feature:
ARB_FIXED_PRIORITY_EN
- Defined: data always wins ties and last_grant is ignored. This matches single-cycle-style load/store priority, and fetch can starve.
- Undefined: round-robin as above.
- Both builds: ports, latency and reset behaviour are identical.

Test Plan:
- Single fetch, MEM_LATENCY=2, ifetch_address=0x40, mem_rdata=0x00500093 -> mem_en high 2 cycles at 0x40; ifetch_ready pulses at N+3 with rdata 0x00500093; data_ready stays 0.
- Store: data_req, we=1, address=0x100, wdata=0xDEADBEEF -> mem_we=1 with mem_wdata 0xDEADBEEF for 2 cycles; data_ready pulses with data_rdata=0.
- Both requests held continuously from reset -> grants alternate data, fetch, data, fetch, one grant every 4 cycles. With ARB_FIXED_PRIORITY_EN, only data is granted.
- data_req dropped one cycle after grant -> the access still runs; data_ready still pulses once at N+3.
- Reset asserted in the 2nd ACCESS cycle -> next cycle state is IDLE, all outputs 0, no ready pulse; a fresh fetch afterwards completes normally.
- MEM_LATENCY=1, back-to-back fetches with req held after ready -> ready pulses every 3 cycles; mem_en high 1 cycle per access.

Source files
------------

// File: rtl/unified_memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store.
// Define ARB_FIXED_PRIORITY_EN to make data win every tie (fetch may then starve).
module unified_memory_arbiter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 2   // legal range 1..15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifetch_req,
  input  logic [ADDR_WIDTH-1:0] ifetch_address,
  output logic                  ifetch_ready,
  output logic [DATA_WIDTH-1:0] ifetch_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  arb_busy,
  output logic                  grant_owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  localparam logic [3:0] LOAD_COUNT = 4'(MEM_LATENCY - 1);

  state_t     state;
  logic [3:0] count;
  logic       pick_data;

  // grant_owner doubles as last_grant: it always names the most recent winner.
`ifdef ARB_FIXED_PRIORITY_EN
  assign pick_data = data_req;
`else
  assign pick_data = data_req && (!ifetch_req || !grant_owner);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: every output is a register, so reset clears the memory interface and the rdata buses alike.
      state        <= IDLE;
      count        <= '0;
      ifetch_ready <= 1'b0;
      ifetch_rdata <= '0;
      data_ready   <= 1'b0;
      data_rdata   <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      arb_busy     <= 1'b0;
      grant_owner  <= 1'b0;
    end else begin
      // NOTE: ready defaults low every cycle, so it can only ever be a one-cycle pulse.
      ifetch_ready <= 1'b0;
      data_ready   <= 1'b0;
      case (state)
        IDLE: begin
          if (ifetch_req || data_req) begin
            grant_owner <= pick_data;
            mem_address <= pick_data ? data_address : ifetch_address;
            mem_wdata   <= pick_data ? data_wdata : '0;
            mem_we      <= pick_data && data_we;
            mem_en      <= 1'b1;
            arb_busy    <= 1'b1;
            count       <= LOAD_COUNT;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (grant_owner) begin
              data_ready <= 1'b1;
              data_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
              ifetch_ready <= 1'b1;
              ifetch_rdata <= mem_rdata;
            end
            state <= RESPOND;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESPOND: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Self-checking bench for unified_memory_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of grants, latency windows and a shadow memory.
module tb_unified_memory_arbiter;

  localparam int L = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifetch_req;
  logic [63:0] ifetch_address;
  logic        ifetch_ready;
  logic [63:0] ifetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [63:0] data_address;
  logic [63:0] data_wdata;
  logic        data_ready;
  logic [63:0] data_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        arb_busy;
  logic        grant_owner;

  // second instance with MEM_LATENCY=1, fetch side only
  logic        f1_req;
  logic [63:0] f1_address;
  logic        f1_ready;
  logic [63:0] f1_rdata;
  logic        d1_ready;
  logic [63:0] d1_rdata;
  logic        f1_mem_en;
  logic        f1_mem_we;
  logic [63:0] f1_mem_address;
  logic [63:0] f1_mem_wdata;
  logic [63:0] f1_mem_rdata;
  logic        f1_busy;
  logic        f1_owner;

  int n_tests;
  int n_fail;

  always #5 clock = ~clock;

  unified_memory_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .ifetch_req(ifetch_req), .ifetch_address(ifetch_address),
    .ifetch_ready(ifetch_ready), .ifetch_rdata(ifetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_address(data_address),
    .data_wdata(data_wdata), .data_ready(data_ready), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .arb_busy(arb_busy), .grant_owner(grant_owner)
  );

  unified_memory_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset),
    .ifetch_req(f1_req), .ifetch_address(f1_address),
    .ifetch_ready(f1_ready), .ifetch_rdata(f1_rdata),
    .data_req(1'b0), .data_we(1'b0), .data_address(64'h0),
    .data_wdata(64'h0), .data_ready(d1_ready), .data_rdata(d1_rdata),
    .mem_en(f1_mem_en), .mem_we(f1_mem_we), .mem_address(f1_mem_address),
    .mem_wdata(f1_mem_wdata), .mem_rdata(f1_mem_rdata),
    .arb_busy(f1_busy), .grant_owner(f1_owner)
  );

  assign f1_mem_rdata = ~f1_mem_address;

  // Memory macro: 4096 words indexed by address[11:0], untouched words read a fixed pattern.
  logic [63:0] mem_arr [4096];
  bit          written [4096];

  function automatic logic [63:0] init_val(input logic [11:0] a);
    if (a == 12'h040) return 64'h0000_0000_0050_0093;
    return ({52'h0, a} * 64'h9E37_79B9_7F4A_7C15) ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_address[11:0]] <= mem_wdata;
      written[mem_address[11:0]] <= 1'b1;
    end
  end

  always @(negedge clock) begin
    mem_rdata = written[mem_address[11:0]] ? mem_arr[mem_address[11:0]] : init_val(mem_address[11:0]);
  end

  // Reference model: one transaction at a time, described by its grant edge.
  logic [63:0] shadow [4096];
  int          ecnt = 0;
  int          free_edge = 0;
  int          g_edge = 0;
  bit          act = 1'b0;
  logic        last_owner = 1'b0;
  logic        t_owner, t_we;
  logic [63:0] t_addr, t_wdata, t_rdata;
  logic        e_mem_en, e_mem_we, e_busy, e_iready, e_dready, e_owner;

  task automatic model_edge();
    int   k;
    logic pick;
    ecnt++;
    if (reset) begin
      act        = 1'b0;
      last_owner = 1'b0;
      free_edge  = ecnt + 1;
    end else begin
      if (act && ecnt > g_edge + L) act = 1'b0;
      if (!act && ecnt >= free_edge && (ifetch_req || data_req)) begin
`ifdef ARB_FIXED_PRIORITY_EN
        pick = data_req;
`else
        if (ifetch_req && data_req) pick = !last_owner;
        else pick = data_req;
`endif
        t_owner    = pick;
        last_owner = pick;
        t_we       = pick && data_we;
        t_addr     = pick ? data_address : ifetch_address;
        t_wdata    = data_wdata;
        t_rdata    = t_we ? 64'h0 : shadow[t_addr[11:0]];
        g_edge     = ecnt;
        free_edge  = ecnt + L + 2;
        act        = 1'b1;
      end
    end
    k        = ecnt - g_edge;
    e_mem_en = act && k < L;
    e_mem_we = e_mem_en && t_we;
    e_busy   = act;
    e_iready = act && k == L && !t_owner;
    e_dready = act && k == L && t_owner;
    e_owner  = last_owner;
    if (act && k == L && t_we) shadow[t_addr[11:0]] = t_wdata;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    model_edge();
  endtask

  function automatic logic [63:0] rand_addr();
    return {$urandom(), 20'($urandom()), 12'($urandom_range(0, 15) * 8)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({ifetch_ready, data_ready, mem_en, mem_we, arb_busy, grant_owner} !== 6'b0 ||
        mem_address !== 64'h0 || mem_wdata !== 64'h0 || ifetch_rdata !== 64'h0 || data_rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctrl=%b addr=%h wdata=%h irdata=%h drdata=%h, expected all zero",
               {ifetch_ready, data_ready, mem_en, mem_we, arb_busy, grant_owner},
               mem_address, mem_wdata, ifetch_rdata, data_rdata);
    end
    n_tests++;
    if ({f1_ready, d1_ready, f1_mem_en, f1_mem_we, f1_busy, f1_owner} !== 6'b0 ||
        f1_mem_address !== 64'h0 || f1_mem_wdata !== 64'h0 || f1_rdata !== 64'h0 || d1_rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_lat1: got ctrl=%b, expected all zero",
               {f1_ready, d1_ready, f1_mem_en, f1_mem_we, f1_busy, f1_owner});
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if ({ifetch_ready, data_ready, mem_en, arb_busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_no_request: got %b expected 0000", {ifetch_ready, data_ready, mem_en, arb_busy});
    end
  endtask

  task automatic test_single_fetch();
    int          ready_at = -1;
    int          ready_cnt = 0;
    int          en_cnt = 0;
    logic [63:0] got = 'x;
    ifetch_address = 64'h40;
    ifetch_req     = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (mem_en) begin
        en_cnt++;
        n_tests++;
        if (mem_address !== 64'h40 || mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_mem_bus: got addr=%h we=%b expected addr=40 we=0", mem_address, mem_we);
        end
      end
      n_tests++;
      if (data_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_no_data_ready: got %b expected 0", data_ready);
      end
      if (ifetch_ready) begin
        if (ready_at < 0) ready_at = n;
        ready_cnt++;
        got        = ifetch_rdata;
        ifetch_req = 1'b0;
      end
    end
    n_tests++;
    if (ready_at != L + 1 || ready_cnt != 1) begin
      n_fail++;
      $display("FAIL fetch_ready_timing: got cycle %0d count %0d expected cycle %0d count 1", ready_at, ready_cnt, L + 1);
    end
    n_tests++;
    if (en_cnt != L) begin
      n_fail++;
      $display("FAIL fetch_mem_en_cycles: got %0d expected %0d", en_cnt, L);
    end
    n_tests++;
    if (got !== 64'h0050_0093) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h expected 0000000000500093", got);
    end
  endtask

  task automatic test_store();
    int          ready_at = -1;
    int          en_cnt = 0;
    logic [63:0] got = 'x;
    data_we      = 1'b1;
    data_address = 64'h100;
    data_wdata   = 64'hDEAD_BEEF;
    data_req     = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (mem_en) begin
        en_cnt++;
        n_tests++;
        if (mem_we !== 1'b1 || mem_wdata !== 64'hDEAD_BEEF || mem_address !== 64'h100) begin
          n_fail++;
          $display("FAIL store_mem_bus: got we=%b wdata=%h addr=%h expected we=1 wdata=deadbeef addr=100",
                   mem_we, mem_wdata, mem_address);
        end
      end
      n_tests++;
      if (ifetch_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL store_no_fetch_ready: got %b expected 0", ifetch_ready);
      end
      if (data_ready) begin
        if (ready_at < 0) ready_at = n;
        got      = data_rdata;
        data_req = 1'b0;
      end
    end
    data_we = 1'b0;
    n_tests++;
    if (ready_at != L + 1 || en_cnt != L) begin
      n_fail++;
      $display("FAIL store_timing: got ready cycle %0d en cycles %0d expected %0d and %0d", ready_at, en_cnt, L + 1, L);
    end
    n_tests++;
    if (got !== 64'h0) begin
      n_fail++;
      $display("FAIL store_rdata_zero: got %h expected 0", got);
    end
  endtask

  task automatic test_drop_req();
    int          ready_at = -1;
    int          ready_cnt = 0;
    logic [63:0] got = 'x;
    data_we      = 1'b0;
    data_address = 64'h100;
    data_req     = 1'b1;
    tick();
    data_req = 1'b0;
    n_tests++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_req_granted: got mem_en=%b expected 1", mem_en);
    end
    for (int n = 2; n <= 8; n++) begin
      tick();
      if (data_ready) begin
        if (ready_at < 0) ready_at = n;
        ready_cnt++;
        got = data_rdata;
      end
    end
    n_tests++;
    if (ready_at != L + 1 || ready_cnt != 1) begin
      n_fail++;
      $display("FAIL drop_req_ready: got cycle %0d count %0d expected cycle %0d count 1", ready_at, ready_cnt, L + 1);
    end
    n_tests++;
    if (got !== 64'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_after_store: got %h expected deadbeef", got);
    end
  endtask

  task automatic test_round_robin();
    int   grants = 0;
    int   gcyc [8];
    logic gown [8];
    logic prev_en;
    logic exp_own;
    reset          = 1'b1;
    ifetch_address = 64'h200;
    data_address   = 64'h308;
    data_we        = 1'b0;
    ifetch_req     = 1'b1;
    data_req       = 1'b1;
    tick();
    reset   = 1'b0;
    prev_en = mem_en;
    for (int n = 1; n <= 16; n++) begin
      tick();
      n_tests++;
      if ({ifetch_ready, data_ready, mem_en, arb_busy, grant_owner} !== {e_iready, e_dready, e_mem_en, e_busy, e_owner}) begin
        n_fail++;
        $display("FAIL rr_ctrl cycle %0d: got %b expected %b", n,
                 {ifetch_ready, data_ready, mem_en, arb_busy, grant_owner}, {e_iready, e_dready, e_mem_en, e_busy, e_owner});
      end
      if (mem_en && !prev_en && grants < 8) begin
        gcyc[grants] = n;
        gown[grants] = grant_owner;
        grants++;
      end
      prev_en = mem_en;
    end
    ifetch_req = 1'b0;
    data_req   = 1'b0;
    n_tests++;
    if (grants != 4) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d expected 4", grants);
    end
    for (int k = 0; k < grants && k < 4; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      exp_own = 1'b1;
`else
      exp_own = (k % 2 == 0);
`endif
      n_tests++;
      if (gown[k] !== exp_own || gcyc[k] != 1 + k * (L + 2)) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got owner %b at cycle %0d expected owner %b at cycle %0d",
                 k, gown[k], gcyc[k], exp_own, 1 + k * (L + 2));
      end
    end
    repeat (L + 2) tick();
  endtask

  task automatic test_reset_mid_access();
    int          ready_at = -1;
    logic [63:0] got = 'x;
    ifetch_address = 64'h0000_1234_0000_0088;
    ifetch_req     = 1'b1;
    tick();
    tick();
    n_tests++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_in_access: got mem_en=%b expected 1", mem_en);
    end
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    ifetch_req = 1'b0;
    n_tests++;
    if ({ifetch_ready, data_ready, mem_en, mem_we, arb_busy, grant_owner} !== 6'b0 ||
        mem_address !== 64'h0 || ifetch_rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got ctrl=%b addr=%h expected all zero",
               {ifetch_ready, data_ready, mem_en, mem_we, arb_busy, grant_owner}, mem_address);
    end
    for (int n = 1; n <= 3; n++) begin
      tick();
      n_tests++;
      if ({ifetch_ready, data_ready, mem_en} !== 3'b0) begin
        n_fail++;
        $display("FAIL reset_mid_no_pulse cycle %0d: got %b expected 000", n, {ifetch_ready, data_ready, mem_en});
      end
    end
    ifetch_address = 64'h40;
    ifetch_req     = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (ifetch_ready) begin
        if (ready_at < 0) ready_at = n;
        got        = ifetch_rdata;
        ifetch_req = 1'b0;
      end
    end
    n_tests++;
    if (ready_at != L + 1 || got !== 64'h0050_0093) begin
      n_fail++;
      $display("FAIL reset_mid_fresh_fetch: got cycle %0d rdata %h expected cycle %0d rdata 500093", ready_at, got, L + 1);
    end
  endtask

  task automatic test_latency1();
    int          rcnt = 0;
    int          en_total = 0;
    logic [63:0] cur;
    f1_address = 64'h40;
    cur        = f1_address;
    f1_req     = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (f1_mem_en) en_total++;
      if (f1_ready) begin
        rcnt++;
        n_tests++;
        if ((n - 2) % 3 != 0 || f1_rdata !== ~cur) begin
          n_fail++;
          $display("FAIL lat1_ready: cycle %0d rdata %h expected cycle 2+3k rdata %h", n, f1_rdata, ~cur);
        end
        f1_address = rand_addr();
        cur        = f1_address;
      end
    end
    f1_req = 1'b0;
    n_tests++;
    if (rcnt != 4 || en_total != 4) begin
      n_fail++;
      $display("FAIL lat1_throughput: got %0d readies %0d en cycles expected 4 and 4", rcnt, en_total);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if (ifetch_ready) ifetch_req = 1'b0;
      if (data_ready) data_req = 1'b0;
      if (!ifetch_req && $urandom_range(0, 3) == 0) begin
        ifetch_req     = 1'b1;
        ifetch_address = rand_addr();
      end else if (ifetch_req && $urandom_range(0, 31) == 0) begin
        ifetch_req = 1'b0;
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req     = 1'b1;
        data_we      = 1'($urandom_range(0, 1));
        data_address = rand_addr();
        data_wdata   = {$urandom(), $urandom()};
      end else if (data_req && $urandom_range(0, 31) == 0) begin
        data_req = 1'b0;
      end
      tick();
      n_tests++;
      if ({ifetch_ready, data_ready, mem_en, mem_we, arb_busy, grant_owner} !==
          {e_iready, e_dready, e_mem_en, e_mem_we, e_busy, e_owner}) begin
        n_fail++;
        $display("FAIL random_ctrl cycle %0d: got %b expected %b", n,
                 {ifetch_ready, data_ready, mem_en, mem_we, arb_busy, grant_owner},
                 {e_iready, e_dready, e_mem_en, e_mem_we, e_busy, e_owner});
      end
      if (e_mem_en) begin
        n_tests++;
        if (mem_address !== t_addr || (e_mem_we && mem_wdata !== t_wdata)) begin
          n_fail++;
          $display("FAIL random_mem_bus cycle %0d: got addr=%h wdata=%h expected addr=%h wdata=%h",
                   n, mem_address, mem_wdata, t_addr, t_wdata);
        end
      end
      if (e_iready) begin
        n_tests++;
        if (ifetch_rdata !== t_rdata) begin
          n_fail++;
          $display("FAIL random_ifetch_rdata cycle %0d: got %h expected %h", n, ifetch_rdata, t_rdata);
        end
      end
      if (e_dready) begin
        n_tests++;
        if (data_rdata !== t_rdata) begin
          n_fail++;
          $display("FAIL random_data_rdata cycle %0d: got %h expected %h", n, data_rdata, t_rdata);
        end
      end
    end
    ifetch_req = 1'b0;
    data_req   = 1'b0;
    repeat (L + 3) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4096; i++) shadow[i] = init_val(12'(i));
    reset          = 1'b1;
    ifetch_req     = 1'b0;
    ifetch_address = 64'h0;
    data_req       = 1'b0;
    data_we        = 1'b0;
    data_address   = 64'h0;
    data_wdata     = 64'h0;
    f1_req         = 1'b0;
    f1_address     = 64'h0;
    test_reset();
    test_single_fetch();
    test_store();
    test_drop_req();
    test_round_robin();
    test_reset_mid_access();
    test_latency1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
